// File: rtl/bram_stream_reader_if.sv
// Command, output stream and RAM port bundle for bram_stream_reader.
// The master modport is the reader itself; slave is the surrounding logic.
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  bram_en;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_di;
  logic [DATA_WIDTH-1:0] bram_do;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    input  out_ready, bram_do,
    output cmd_ready, out_valid, out_data, out_last,
    output bram_en, bram_we, bram_addr, bram_di, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    output out_ready, bram_do,
    input  cmd_ready, out_valid, out_data, out_last,
    input  bram_en, bram_we, bram_addr, bram_di, busy
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Burst reader for single-cycle-latency block RAMs; a 2-entry
// credit-managed buffer hides the read latency on the output stream.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6
) (
  input logic                    clk,
  input logic                    resetn,
  bram_stream_reader_if.master   bus
);
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  inflight;
  logic                  inflight_last;
  logic [DATA_WIDTH-1:0] fdata [2];
  logic [1:0]            flast;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic [1:0]            pending;
  logic                  pop;
  logic                  issue;

  assign pop     = (count != 2'd0) && bus.out_ready;
  assign pending = count + {1'b0, inflight};
  // A pop this cycle frees a slot, so issue may resume in the same cycle.
  assign issue   = (state == ISSUE) &&
                   ((pending - {1'b0, pop}) < 2'd2);

  assign bus.cmd_ready = (state == IDLE);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = fdata[rd_ptr];
  assign bus.out_last  = flast[rd_ptr];
  assign bus.bram_en   = issue;
  assign bus.bram_addr = issue ? addr : last_addr;
  assign bus.bram_we   = 1'b0;
  assign bus.bram_di   = '0;
  assign bus.busy      = (state == ISSUE) || inflight ||
                         (count != 2'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      last_addr     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fdata[0]      <= '0;
      fdata[1]      <= '0;
      flast         <= 2'b00;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
    end else begin
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (inflight) begin
        fdata[wr_ptr] <= bus.bram_do;
        flast[wr_ptr] <= inflight_last;
        wr_ptr        <= ~wr_ptr;
      end
      count    <= count + {1'b0, inflight} - {1'b0, pop};
      inflight <= issue;
      if (issue) begin
        inflight_last <= (remaining == '0);
        last_addr     <= addr;
        addr          <= addr + 1'b1;
        remaining     <= remaining - 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr      <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue && (remaining == '0))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench: RAM model, burst vector table, scoreboard
// of expected words and addresses, plus stall/overlap/reset sequences.
module tb_bram_stream_reader;
  logic clk = 1'b0;
  logic resetn;

  bram_stream_reader_if #(.DATA_WIDTH(128), .ADDR_WIDTH(6)) bus ();

  bram_stream_reader #(.DATA_WIDTH(128), .ADDR_WIDTH(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    logic [5:0] addr;
    logic [5:0] len;
    logic [3:0] pat;
    int         words;
  } vec_t;

  exp_t       sbq [$];
  logic [5:0] aq [$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int rcyc = 0;
  int issued_n = 0;
  int popped_n = 0;
  int words_got = 0;
  int acc_n = -1;
  int first_valid_n = -1;
  int first_pop_n = -1;
  int last_pop_n = -1;
  logic acc_flag = 1'b0;
  logic [3:0] rdy_pat = 4'hF;
  logic stalled = 1'b0;
  logic [127:0] held_data;
  logic held_last;

  function automatic logic [127:0] word_of(input logic [5:0] a);
    return {32'(a) ^ 32'h5A5A_0000, 32'h0,
            32'(a) + 32'h100, 32'(a)};
  endfunction

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, got, want, ncyc);
    end
  endtask

  // single-cycle-latency RAM
  always @(posedge clk)
    if (bus.bram_en)
      bus.bram_do <= word_of(bus.bram_addr);

  always @(negedge clk) begin
    logic pop_now;
    logic [5:0] a;
    ncyc++;
    if (resetn) begin
      chk("bram_we", {127'b0, bus.bram_we}, 128'd0);
      chk("bram_di", bus.bram_di, 128'd0);
      pop_now = bus.out_valid && bus.out_ready;
      if (bus.cmd_valid && bus.cmd_ready) begin
        for (int k = 0; k <= int'(bus.cmd_len); k++) begin
          a = bus.cmd_addr + 6'(k);
          sbq.push_back('{data: word_of(a),
                          last: (k == int'(bus.cmd_len))});
          aq.push_back(a);
        end
        acc_flag = 1'b1;
        acc_n = ncyc;
      end
      if (bus.bram_en) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL bram_issue: got unexpected read of %0d",
                   bus.bram_addr);
        end else begin
          chk("bram_addr", 128'(bus.bram_addr), 128'(aq.pop_front()));
        end
        chk("credit", 128'((issued_n - popped_n - int'(pop_now)) < 2),
            128'd1);
        issued_n++;
      end
      if (stalled) begin
        chk("stall_valid", {127'b0, bus.out_valid}, 128'd1);
        chk("stall_data", bus.out_data, held_data);
        chk("stall_last", {127'b0, bus.out_last}, {127'b0, held_last});
      end
      if (bus.out_valid && first_valid_n < 0)
        first_valid_n = ncyc;
      if (pop_now) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_word: got unexpected word %0h",
                   bus.out_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_last", {127'b0, bus.out_last}, {127'b0, e.last});
        end
        popped_n++;
        words_got++;
        if (first_pop_n < 0) first_pop_n = ncyc;
        last_pop_n = ncyc;
      end
      stalled   = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      held_last = bus.out_last;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_flag) begin
      bus.cmd_valid = 1'b0;
      acc_flag = 1'b0;
    end
    bus.out_ready = rdy_pat[rcyc % 4];
    rcyc++;
  endtask

  task automatic clear_stats();
    words_got = 0;
    first_valid_n = -1;
    first_pop_n = -1;
    last_pop_n = -1;
    rcyc = 0;
  endtask

  task automatic send(input logic [5:0] a, input logic [5:0] l);
    int budget;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    budget = 0;
    while (bus.cmd_valid && budget < 200) begin
      tick();
      budget++;
    end
    if (bus.cmd_valid) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got no handshake within %0d cycles",
               budget);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((sbq.size() != 0 || aq.size() != 0 || bus.busy) &&
           budget < 600) begin
      tick();
      budget++;
    end
    if (budget >= 600) begin
      checks++; errors++;
      $display("FAIL drain: got %0d words outstanding, expected 0",
               sbq.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {127'b0, bus.cmd_ready}, 128'd1);
    chk({tag, "_out_valid"}, {127'b0, bus.out_valid}, 128'd0);
    chk({tag, "_out_data"}, bus.out_data, 128'd0);
    chk({tag, "_out_last"}, {127'b0, bus.out_last}, 128'd0);
    chk({tag, "_bram_en"}, {127'b0, bus.bram_en}, 128'd0);
    chk({tag, "_bram_addr"}, 128'(bus.bram_addr), 128'd0);
    chk({tag, "_busy"}, {127'b0, bus.busy}, 128'd0);
  endtask

  vec_t vecs [5];

  initial begin
    int base;
    vecs[0] = '{addr: 6'd0,  len: 6'd3,  pat: 4'b1111, words: 4};
    vecs[1] = '{addr: 6'd62, len: 6'd3,  pat: 4'b1111, words: 4};
    vecs[2] = '{addr: 6'd0,  len: 6'd63, pat: 4'b1001, words: 64};
    vecs[3] = '{addr: 6'd17, len: 6'd0,  pat: 4'b1010, words: 1};
    vecs[4] = '{addr: 6'd33, len: 6'd10, pat: 4'b0110, words: 11};

    resetn        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    resetn = 1'b1;

    foreach (vecs[i]) begin
      rdy_pat = vecs[i].pat;
      clear_stats();
      send(vecs[i].addr, vecs[i].len);
      drain();
      chk("burst_words", 128'(words_got), 128'(vecs[i].words));
      // acceptance sampled on the negedge before E0; valid after E2
      chk("first_latency", 128'(first_valid_n - acc_n), 128'd3);
      if (vecs[i].pat == 4'b1111)
        chk("consecutive", 128'(last_pop_n - first_pop_n),
            128'(vecs[i].len));
    end

    rdy_pat = 4'b0000;
    bus.out_ready = 1'b0;
    clear_stats();
    base = issued_n;
    send(6'd8, 6'd5);
    repeat (10) tick();
    chk("bp_issued", 128'(issued_n - base), 128'd2);
    chk("bp_valid", {127'b0, bus.out_valid}, 128'd1);
    chk("bp_head", bus.out_data, word_of(6'd8));
    chk("bp_en_idle", {127'b0, bus.bram_en}, 128'd0);
    rdy_pat = 4'b1111;
    drain();
    chk("bp_words", 128'(words_got), 128'd6);
    chk("bp_flow", 128'(last_pop_n - first_pop_n), 128'd5);

    rdy_pat = 4'b1111;
    clear_stats();
    send(6'd4, 6'd1);
    send(6'd40, 6'd0);
    drain();
    chk("b2b_words", 128'(words_got), 128'd3);

    clear_stats();
    send(6'd10, 6'd20);
    repeat (4) tick();
    chk("pre_reset_valid", {127'b0, bus.out_valid}, 128'd1);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sbq.delete();
    aq.delete();
    acc_flag = 1'b0;
    bus.cmd_valid = 1'b0;
    issued_n = 0;
    popped_n = 0;
    repeat (2) tick();
    resetn = 1'b1;
    clear_stats();
    send(6'd20, 6'd2);
    drain();
    chk("post_reset_words", 128'(words_got), 128'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
